// File: rtl/ir_key_ctrl.sv
// ir_key_ctrl: turns a decoded IR key code stream into press / repeat /
// release key events, queued in a 4-deep show-ahead event FIFO.
//
// Ports:
//   clk27        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   enable       1 = generate key events, 0 = suppress (FSM held in IDLE)
//   ir_code      decoded {address, command}; 0 = no key held
//   ir_code_ack  one-cycle pulse, ir_code holds a newly validated frame
//   evt_rd       pop head event (ignored when empty)
//   ovf_clr      clear sticky overflow flag
//   evt_valid    FIFO non-empty
//   evt_type     head event type: 01 press, 10 repeat, 11 release (0 when empty)
//   evt_code     head event key code (0 when empty)
//   evt_level    FIFO occupancy 0..4
//   overflow     sticky, set when an event was dropped on a full FIFO
//   key_held     1 when the FSM is not IDLE
module ir_key_ctrl #(
    parameter int unsigned REPEAT_DELAY  = 13500000,
    parameter int unsigned REPEAT_PERIOD = 4050000
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] ir_code,
    input  logic        ir_code_ack,
    input  logic        evt_rd,
    input  logic        ovf_clr,
    output logic        evt_valid,
    output logic [1:0]  evt_type,
    output logic [15:0] evt_code,
    output logic [2:0]  evt_level,
    output logic        overflow,
    output logic        key_held
);

    localparam logic [1:0]  EVT_PRESS   = 2'b01;
    localparam logic [1:0]  EVT_REPEAT  = 2'b10;
    localparam logic [1:0]  EVT_RELEASE = 2'b11;
    localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, PEND_PRESS} state_t;

    state_t      state, state_nx;
    logic [15:0] cur_code, cur_code_nx;
    logic [23:0] timer, timer_nx;
    logic        push;
    logic [1:0]  push_type;
    logic [15:0] push_code;

    // ---------------- key FSM ----------------
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_code <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nx;
            cur_code <= cur_code_nx;
            timer    <= timer_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cur_code_nx = cur_code;
        timer_nx    = timer;
        push        = 1'b0;
        push_type   = 2'b00;
        push_code   = cur_code;
        if (!enable) begin
            // Held key is abandoned silently: no RELEASE is queued.
            state_nx = IDLE;
            timer_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ir_code_ack && ir_code != '0) begin
                        push        = 1'b1;
                        push_type   = EVT_PRESS;
                        push_code   = ir_code;
                        cur_code_nx = ir_code;
                        timer_nx    = '0;
                        state_nx    = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    timer_nx = timer + 24'd1;
                    // Release beats a new key, which beats timer expiry.
                    if (ir_code == '0) begin
                        push      = 1'b1;
                        push_type = EVT_RELEASE;
                        timer_nx  = '0;
                        state_nx  = IDLE;
                    end else if (ir_code_ack && ir_code != cur_code) begin
                        push        = 1'b1;
                        push_type   = EVT_RELEASE;
                        cur_code_nx = ir_code;
                        state_nx    = PEND_PRESS;
                    end else if (timer == ((state == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        push      = 1'b1;
                        push_type = EVT_REPEAT;
                        timer_nx  = '0;
                        state_nx  = REPEAT;
                    end
                end
                PEND_PRESS: begin
                    // cur_code already holds the new key from the previous cycle.
                    push      = 1'b1;
                    push_type = EVT_PRESS;
                    timer_nx  = '0;
                    state_nx  = DELAY;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign key_held = (state != IDLE);

    // ---------------- event FIFO ----------------
    logic [17:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  level;
    logic        full, pop, wr_en, drop;

    assign full  = (level == 3'd4);
    assign pop   = evt_rd && (level != 3'd0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk27) begin
        if (wr_en) mem[wr_ptr] <= {push_type, push_code};
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (pop)   rd_ptr <= rd_ptr + 2'd1;
            case ({wr_en, pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign evt_valid = (level != 3'd0);
    assign evt_level = level;
    assign {evt_type, evt_code} = evt_valid ? mem[rd_ptr] : 18'd0;

endmodule

// File: tb/tb_ir_key_ctrl.sv
module tb_ir_key_ctrl;

    logic        clk27 = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] ir_code = '0;
    logic        ir_code_ack = 1'b0;
    logic        evt_rd = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        evt_valid;
    logic [1:0]  evt_type;
    logic [15:0] evt_code;
    logic [2:0]  evt_level;
    logic        overflow;
    logic        key_held;

    int checks = 0;
    int errors = 0;

    ir_key_ctrl #(.REPEAT_DELAY(100), .REPEAT_PERIOD(40)) dut (
        .clk27(clk27), .reset_n(reset_n), .enable(enable), .ir_code(ir_code),
        .ir_code_ack(ir_code_ack), .evt_rd(evt_rd), .ovf_clr(ovf_clr),
        .evt_valid(evt_valid), .evt_type(evt_type), .evt_code(evt_code),
        .evt_level(evt_level), .overflow(overflow), .key_held(key_held)
    );

    always #5 clk27 = ~clk27;

    task automatic tick(input int n);
        repeat (n) @(negedge clk27);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [1:0] t, input logic [15:0] c);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_type"},  32'(evt_type),  32'(t));
        chk({tag, "_code"},  32'(evt_code),  32'(c));
    endtask

    task automatic pop;
        evt_rd = 1'b1;
        tick(1);
        evt_rd = 1'b0;
    endtask

    task automatic ack(input logic [15:0] c);
        ir_code = c;
        ir_code_ack = 1'b1;
        tick(1);
        ir_code_ack = 1'b0;
    endtask

    initial begin
        tick(1);
        #1;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_type",  32'(evt_type),  0);
        chk("rst_code",  32'(evt_code),  0);
        chk("rst_level", 32'(evt_level), 0);
        chk("rst_ovf",   32'(overflow),  0);
        chk("rst_held",  32'(key_held),  0);
        tick(1);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(2);

        // Ack with code 0 in IDLE is ignored
        ack(16'h0000);
        chk("ack0_level", 32'(evt_level), 0);
        chk("ack0_held",  32'(key_held),  0);

        // Press / repeat timing / release
        ack(16'h10EF);                          // N0
        head("press", 2'b01, 16'h10EF);
        chk("press_held", 32'(key_held), 1);
        pop();                                  // N1
        tick(98);                               // N99
        chk("rep1_early", 32'(evt_level), 0);
        tick(1);                                // N100
        head("rep1", 2'b10, 16'h10EF);
        pop();
        tick(38);                               // N139
        chk("rep2_early", 32'(evt_level), 0);
        tick(1);                                // N140
        head("rep2", 2'b10, 16'h10EF);
        pop();
        tick(38);                               // N179
        chk("rep3_early", 32'(evt_level), 0);
        tick(1);                                // N180
        head("rep3", 2'b10, 16'h10EF);
        pop();                                  // N181
        tick(19);                               // N200
        ir_code = 16'h0000;
        tick(1);
        head("rel", 2'b11, 16'h10EF);
        chk("rel_held", 32'(key_held), 0);
        chk("rel_level", 32'(evt_level), 1);
        pop();
        chk("rel_empty", 32'(evt_valid), 0);

        // Key change while held
        ack(16'h10EF);                          // N0
        head("k1_press", 2'b01, 16'h10EF);
        pop();                                  // N1
        tick(48);                               // N49
        ack(16'h20DF);                          // N50
        head("chg_rel", 2'b11, 16'h10EF);
        chk("chg_held", 32'(key_held), 1);
        chk("chg_level", 32'(evt_level), 1);
        pop();                                  // N51
        head("chg_press", 2'b01, 16'h20DF);
        chk("chg_level2", 32'(evt_level), 1);
        pop();                                  // N52
        tick(98);                               // N150
        chk("chg_rep_early", 32'(evt_level), 0);
        tick(1);                                // N151
        head("chg_rep", 2'b10, 16'h20DF);
        pop();                                  // N152

        // enable=0 during REPEAT
        enable = 1'b0;
        tick(1);
        chk("dis_held", 32'(key_held), 0);
        chk("dis_level", 32'(evt_level), 0);
        tick(100);
        chk("dis_quiet", 32'(evt_level), 0);
        enable = 1'b1;
        tick(5);
        chk("en_no_evt", 32'(evt_level), 0);
        ir_code = 16'h0000;
        tick(2);
        chk("en_no_rel", 32'(evt_level), 0);

        // Pop when empty
        pop();
        chk("empty_pop_level", 32'(evt_level), 0);
        chk("empty_pop_valid", 32'(evt_valid), 0);
        chk("empty_pop_type",  32'(evt_type), 0);
        chk("empty_pop_code",  32'(evt_code), 0);

        // Six events without reads: P1111 R1111 P2222 R2222 | P3333 R3333 dropped
        ack(16'h1111);
        ack(16'h2222);
        tick(1);
        chk("fill_level3", 32'(evt_level), 3);
        ack(16'h3333);
        chk("fill_level4", 32'(evt_level), 4);
        chk("fill_noovf", 32'(overflow), 0);
        tick(1);
        chk("ovf_set", 32'(overflow), 1);
        ir_code = 16'h0000;
        tick(1);
        chk("ovf_level", 32'(evt_level), 4);
        chk("ovf_held", 32'(key_held), 0);
        head("ovf_head", 2'b01, 16'h1111);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Full FIFO, read coincident with push
        ir_code = 16'h4444;
        ir_code_ack = 1'b1;
        evt_rd = 1'b1;
        tick(1);
        ir_code_ack = 1'b0;
        evt_rd = 1'b0;
        chk("rdwr_level", 32'(evt_level), 4);
        chk("rdwr_ovf", 32'(overflow), 0);
        head("rdwr_h1", 2'b11, 16'h1111);
        pop();
        head("rdwr_h2", 2'b01, 16'h2222);
        pop();
        head("rdwr_h3", 2'b11, 16'h2222);
        pop();
        head("rdwr_tail", 2'b01, 16'h4444);
        pop();
        chk("rdwr_empty", 32'(evt_level), 0);

        // Reset mid-DELAY
        ack(16'h5555);
        tick(1);
        chk("pre_rst_level", 32'(evt_level), 2);
        chk("pre_rst_held", 32'(key_held), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid), 0);
        chk("arst_type",  32'(evt_type),  0);
        chk("arst_code",  32'(evt_code),  0);
        chk("arst_level", 32'(evt_level), 0);
        chk("arst_ovf",   32'(overflow),  0);
        chk("arst_held",  32'(key_held),  0);
        tick(2);
        reset_n = 1'b1;
        tick(120);
        chk("post_rst_level", 32'(evt_level), 0);
        chk("post_rst_held", 32'(key_held), 0);
        ack(16'h5555);
        head("post_rst_press", 2'b01, 16'h5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
